serial_adder: RTL and testbench

// Bit-serial N-bit adder controller that drives one full_adder cell, LSB first.

---
 rtl/serial_adder.sv | 145 ++++++++++++++
 tb/tb_serial_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder (with full_adder cell)
//  Description : Bit-serial LSB-first adder driving a single full-adder cell;
//                reports sum, carry-out, signed overflow and a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a_in,
  input  logic [NUM_BITS-1:0] b_in,
  input  logic                c_init,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum_out,
  output logic                c_final,
  output logic                overflow
);

  localparam int               CNT_W  = $clog2(NUM_BITS);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_BITS-1:0] r_sh_a;
  logic [NUM_BITS-1:0] r_sh_b;
  // Holds the NUM_BITS-1 low sum bits; the MSB comes straight from the cell.
  logic [NUM_BITS-2:0] r_sh_s;
  logic                r_carry;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_BITS-1:0] r_sum;
  logic                r_c_final;
  logic                r_overflow;

  logic                w_s;
  logic                w_c_out;
  logic                w_accept;
  logic                w_last;
  logic [NUM_BITS-1:0] w_sum_cat;

  full_adder u_fa (
    .a     (r_sh_a[0]),
    .b     (r_sh_b[0]),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_c_out)
  );

  assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last    = (r_cnt == C_LAST);
  assign w_sum_cat = {w_s, r_sh_s};

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_ADD;
      end
      S_ADD: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = start ? S_ADD : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sh_a     <= '0;
      r_sh_b     <= '0;
      r_sh_s     <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_c_final  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_sh_a  <= a_in;
      r_sh_b  <= b_in;
      r_carry <= c_init;
      r_cnt   <= '0;
    end else if (r_state == S_ADD) begin
      r_sh_a  <= r_sh_a >> 1;
      r_sh_b  <= r_sh_b >> 1;
      r_sh_s  <= w_sum_cat[NUM_BITS-1:1];
      r_carry <= w_c_out;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum      <= w_sum_cat;
        r_c_final  <= w_c_out;
        // r_carry here is the carry into the MSB position.
        r_overflow <= r_carry ^ w_c_out;
      end
    end
  end

  assign sum_out  = r_sum;
  assign c_final  = r_c_final;
  assign overflow = r_overflow;

`ifndef SYNTHESIS
  a_start_known : assert property (@(posedge clk) disable iff (!n_rst)
    !$isunknown(start));
  a_ops_known : assert property (@(posedge clk) disable iff (!n_rst)
    w_accept |-> !$isunknown({a_in, b_in, c_init}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// Testbench for serial_adder: two instances (8 and 4 bits) checked against an
// arithmetic reference model through per-instance scoreboards.
module tb_serial_adder;

  logic       clk   = 1'b0;
  logic       n_rst = 1'b0;

  logic       start8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cf8, ov8;
  logic [7:0] sum8;

  logic       start4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cf4, ov4;
  logic [3:0] sum4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef logic [33:0] exp_t;  // {overflow, carry out, 32-bit sum}
  exp_t q8[$];
  exp_t q4[$];
  bit   per_chk = 1'b0;

  serial_adder #(.NUM_BITS(8)) u_dut8 (
    .clk(clk), .n_rst(n_rst), .start(start8), .a_in(a8), .b_in(b8),
    .c_init(c8), .busy(busy8), .done(done8), .sum_out(sum8),
    .c_final(cf8), .overflow(ov8)
  );

  serial_adder #(.NUM_BITS(4)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .start(start4), .a_in(a4), .b_in(b4),
    .c_init(c4), .busy(busy4), .done(done4), .sum_out(sum4),
    .c_final(cf4), .overflow(ov4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer addition, signed overflow from operand/result signs.
  function automatic exp_t model(input int n, input logic [31:0] a,
                                 input logic [31:0] b, input logic c);
    logic [31:0] mask;
    logic [63:0] full;
    logic [31:0] s;
    logic        cf, ov;
    mask = (32'd1 << n) - 32'd1;
    full = {32'b0, a & mask} + {32'b0, b & mask} + {63'b0, c};
    s    = full[31:0] & mask;
    cf   = full[n];
    ov   = (a[n-1] == b[n-1]) && (s[n-1] != a[n-1]);
    return {ov, cf, s};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Both monitors: done pops the scoreboard; otherwise outputs must hold.
  int   run8 = 0, last_done8 = 0;
  bit   prev_per8 = 1'b0;
  exp_t last8 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!n_rst) begin
      run8 = 0; last8 = '0; prev_per8 = 1'b0;
    end else if (done8) begin
      chk("busy_len8", 64'(run8), 64'd8);
      if (per_chk && prev_per8) chk("period8", 64'(cyc - last_done8), 64'd9);
      prev_per8  = per_chk;
      last_done8 = cyc;
      run8       = 0;
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL result8: done seen with 0 pending requests, expected none");
      end else begin
        e = q8.pop_front();
        chk("result8", 64'({ov8, cf8, 24'b0, sum8}), 64'(e));
        last8 = e;
      end
    end else begin
      if (busy8) run8++;
      chk("hold8", 64'({ov8, cf8, 24'b0, sum8}), 64'(last8));
    end
  end

  int   run4 = 0;
  exp_t last4 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!n_rst) begin
      run4 = 0; last4 = '0;
    end else if (done4) begin
      chk("busy_len4", 64'(run4), 64'd4);
      run4 = 0;
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL result4: done seen with 0 pending requests, expected none");
      end else begin
        e = q4.pop_front();
        chk("result4", 64'({ov4, cf4, 28'b0, sum4}), 64'(e));
        last4 = e;
      end
    end else begin
      if (busy4) run4++;
      chk("hold4", 64'({ov4, cf4, 28'b0, sum4}), 64'(last4));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after an edge; returns 1 unit into the DONE cycle with
  // start dropped, so an immediate further call runs back-to-back.
  task automatic issue(input bit d4, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    if (d4) begin
      a4 = a[3:0]; b4 = b[3:0]; c4 = c; start4 = 1'b1;
      q4.push_back(model(4, a, b, c));
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; c8 = c; start8 = 1'b1;
      q8.push_back(model(8, a, b, c));
    end
    @(posedge clk);
    repeat (d4 ? 4 : 8) begin
      #1;
      if (d4) begin
        a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom); start4 = 1'($urandom);
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); start8 = 1'($urandom);
      end
      @(posedge clk);
    end
    #1;
    if (d4) start4 = 1'b0;
    else    start8 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset8", 64'({busy8, done8, cf8, ov8, sum8}), 64'd0);
    chk("reset4", 64'({busy4, done4, cf4, ov4, sum4}), 64'd0);
    n_rst = 1'b1;
    idle(2);

    issue(0, 32'h0F, 32'h01, 1'b0); idle(2);
    issue(0, 32'hFF, 32'h01, 1'b0); idle(1);
    issue(0, 32'h7F, 32'h01, 1'b0); idle(1);
    issue(0, 32'hFF, 32'hFF, 1'b1); idle(2);

    // Abort in the third ADD cycle; previous result FF must vanish.
    a8 = 8'h55; b8 = 8'h2A; c8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_before_abort", 64'(busy8), 64'd1);
    n_rst = 1'b0;
    #1;
    chk("abort8", 64'({busy8, done8, cf8, ov8, sum8}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(12);
    chk("idle_after_abort", 64'({busy8, done8}), 64'd0);

    per_chk = 1'b1;
    for (int i = 0; i < 8; i++) issue(0, $urandom, $urandom, 1'($urandom));
    per_chk = 1'b0;
    idle(3);

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          issue(0, $urandom, $urandom, 1'($urandom));
          if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          issue(1, $urandom, $urandom, 1'($urandom));
          if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
      end
    join

    for (int i = 0; i < 50 && (q8.size() != 0 || q4.size() != 0); i++) @(posedge clk);
    total++;
    if (q8.size() != 0 || q4.size() != 0) begin
      bad++;
      $display("FAIL drain: pending8=%0d pending4=%0d expected 0", q8.size(), q4.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
